// File: rtl/seq_trunc_mult.sv
// Iterative truncated-array fractional multiplier: one partial-product row per clock,
// dropped low columns offset by a constant correction, optional exact mode.
module seq_trunc_mult #(
  parameter int N    = 8,
  parameter int K    = 3,
  parameter int CORR = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         exact,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] z
);

  localparam int RW = (N > 2) ? $clog2(N) : 1;
  localparam logic [2*N-1:0] KEEP_MASK = {(2*N){1'b1}} << (N - K);
  localparam logic [2*N-1:0] CORR_INIT = (2*N)'(CORR);
  localparam logic [RW-1:0]  LAST_ROW  = RW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    x_q, x_d;
  logic [N-1:0]    y_q, y_d;
  logic            exact_q, exact_d;
  logic [RW-1:0]   row_q, row_d;
  logic [2*N-1:0]  acc_q, acc_d;
  logic [2*N-1:0]  row_bits;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    exact_d = exact_q;
    row_d   = row_q;
    acc_d   = acc_q;

    // Current row, shifted into its columns; low columns masked off unless exact
    row_bits = y_q[row_q] ? ({{N{1'b0}}, x_q} << row_q) : '0;
    if (!exact_q) begin
      row_bits = row_bits & KEEP_MASK;
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = x;
          y_d     = y;
          exact_d = exact;
          row_d   = '0;
          acc_d   = exact ? '0 : CORR_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = acc_q + row_bits;
        row_d = row_q + RW'(1);
        if (row_q == LAST_ROW) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      exact_q <= 1'b0;
      row_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      exact_q <= exact_d;
      row_q   <= row_d;
      acc_q   <= acc_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign z         = acc_q[2*N-1:N];

endmodule

// File: tb/tb_seq_trunc_mult.sv
// Directed bench for seq_trunc_mult: defaults instance (N=8,K=3,CORR=32) plus an
// untruncated N=4 instance; random section compares against a bit-pair column model.
module tb_seq_trunc_mult;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] x = '0;
  logic [7:0] y = '0;
  logic       exact = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] z;

  logic       in_valid4 = 1'b0;
  logic       in_ready4;
  logic [3:0] x4 = '0;
  logic [3:0] y4 = '0;
  logic       exact4 = 1'b0;
  logic       out_valid4;
  logic       out_ready4 = 1'b1;
  logic [3:0] z4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_trunc_mult #(.N(8), .K(3), .CORR(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .exact(exact), .out_valid(out_valid), .out_ready(out_ready), .z(z)
  );

  seq_trunc_mult #(.N(4), .K(4), .CORR(0)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .x(x4), .y(y4), .exact(exact4), .out_valid(out_valid4), .out_ready(out_ready4), .z(z4)
  );

  // Bit-pair column model for the default parameters
  function automatic logic [7:0] refZ(input logic [7:0] a, input logic [7:0] b, input logic ex);
    int s;
    s = ex ? 0 : 32;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        if (a[j] && b[i] && (ex || (i + j) >= 5)) s += (1 << (i + j));
      end
    end
    return 8'((s >> 8) & 255);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic timeoutFail(input string tag);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out waiting for DUT", tag);
  endtask

  // Present operands and hold in_valid until the accepting edge has passed
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic ex);
    int n;
    n = 0;
    x = a;
    y = b;
    exact = ex;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) timeoutFail("accept");
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic waitValid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!out_valid) timeoutFail("out_valid");
  endtask

  initial begin
    int cyc;
    int n;
    bit done;
    logic [7:0] ra, rb;

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_z", z, 8'h00);
    reset = 1'b0;

    // Scenario 1: exact FF*FF, latency and in_ready low while busy
    out_ready = 1'b1;
    applyStimulus(8'hFF, 8'hFF, 1'b1);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      checkOutput("s1_in_ready_busy", in_ready, 0);
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("s1_latency_edges", cyc, 8);
    checkOutput("s1_in_ready_done", in_ready, 0);
    checkOutput("s1_z_exact_ffff", z, 8'hFE);
    @(posedge clk); #1;
    checkOutput("s1_back_idle", in_ready, 1);

    // Scenario 2/3: truncated vectors
    applyStimulus(8'hFF, 8'hFF, 1'b0);
    waitValid(cyc);
    checkOutput("s2_z_trunc_ffff", z, 8'hFD);
    @(posedge clk); #1;

    applyStimulus(8'h80, 8'h80, 1'b0);
    waitValid(cyc);
    checkOutput("s3_z_trunc_8080", z, 8'h40);
    @(posedge clk); #1;

    applyStimulus(8'h00, 8'hA5, 1'b0);
    waitValid(cyc);
    checkOutput("s3_z_trunc_zero", z, 8'h00);
    @(posedge clk); #1;

    for (int m = 0; m < 2; m++) begin
      x4 = 4'hF;
      y4 = 4'hF;
      exact4 = m[0];
      in_valid4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      n = 0;
      while (!out_valid4 && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      if (!out_valid4) timeoutFail("n4_out_valid");
      checkOutput("s3_n4k4_z_ff", z4, 4'hE);
      @(posedge clk); #1;
    end

    // Scenario 4: backpressure with new operands presented while holding
    out_ready = 1'b0;
    applyStimulus(8'hFF, 8'hFF, 1'b0);
    waitValid(cyc);
    x = 8'h80;
    y = 8'h80;
    exact = 1'b0;
    in_valid = 1'b1;
    repeat (5) begin
      checkOutput("s4_hold_z", z, 8'hFD);
      checkOutput("s4_hold_out_valid", out_valid, 1);
      checkOutput("s4_hold_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("s4_idle_in_ready", in_ready, 1);
    checkOutput("s4_idle_out_valid", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("s4_new_accepted", in_ready, 0);
    waitValid(cyc);
    checkOutput("s4_new_z", z, 8'h40);
    @(posedge clk); #1;

    // Scenario 5: reset mid-BUSY at row 3
    applyStimulus(8'hFF, 8'hFF, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("s5_rst_in_ready", in_ready, 1);
    checkOutput("s5_rst_out_valid", out_valid, 0);
    checkOutput("s5_rst_z", z, 8'h00);
    applyStimulus(8'h80, 8'h80, 1'b1);
    waitValid(cyc);
    checkOutput("s5_after_rst_z", z, 8'h40);
    @(posedge clk); #1;

    // Scenario 6: random pairs in both modes with random out_ready
    for (int k = 0; k < 200; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      for (int m = 0; m < 2; m++) begin
        applyStimulus(ra, rb, m[0]);
        n = 0;
        done = 1'b0;
        while (!done && n < 200) begin
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) begin
            checkOutput("s6_random_z", {24'd0, z}, {24'd0, refZ(ra, rb, m[0])});
            done = 1'b1;
          end
          @(posedge clk); #1;
          n++;
        end
        if (!done) timeoutFail("s6_result");
      end
    end
    out_ready = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
